// File: rtl/display_pkg.sv
// Shared types and constants for the binary-to-BCD display controller.
package display_pkg;

  localparam int unsigned DATA_W       = 16;
  localparam int unsigned NUM_DIGITS   = 5;
  localparam int unsigned SHIFT_CYCLES = 16;
  localparam int unsigned BCD_W        = NUM_DIGITS * 4;
  localparam int unsigned MAG_W        = DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Pre-shift correction so the doubled digit carries correctly into the next one.
  always_comb begin
    digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
  end

endmodule

// File: rtl/display_bcd_ctrl.sv
// Converts a 16-bit value into five registered BCD digits plus sign using a
// sequential double-dabble. Requests arriving mid-conversion are queued one deep.
module display_bcd_ctrl
  import display_pkg::*;
#(
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] value_i,
  output logic [3:0]        bcd_digit0,
  output logic [3:0]        bcd_digit1,
  output logic [3:0]        bcd_digit2,
  output logic [3:0]        bcd_digit3,
  output logic [3:0]        bcd_digit4,
  output logic              negative,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned CntW = $clog2(SHIFT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(SHIFT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]  scratch_q, scratch_d;
  logic [MAG_W-1:0]  mag_q, mag_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] pend_val_q, pend_val_d;
  logic              pend_valid_q, pend_valid_d;
  logic [BCD_W-1:0]  disp_q, disp_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;

  logic [BCD_W-1:0]  adj;
  logic [DATA_W-1:0] ld_val;
  logic [MAG_W-1:0]  ld_mag;
  logic              ld_sign;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (scratch_q[i*4 +: 4]),
      .digit_o (adj[i*4 +: 4])
    );
  end

  // Source of the next conversion: a live request always beats the pending slot.
  always_comb begin
    ld_val = load_i ? value_i : pend_val_q;
    if (SIGNED_EN && ld_val[DATA_W-1]) begin
      // 17-bit negate so -32768 yields +32768 without overflow.
      ld_mag  = MAG_W'(0) - {1'b1, ld_val};
      ld_sign = 1'b1;
    end else begin
      ld_mag  = {1'b0, ld_val};
      ld_sign = 1'b0;
    end
  end

  // Next-state logic for the conversion FSM, datapath and pending slot.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    scratch_d    = scratch_q;
    mag_d        = mag_q;
    sign_d       = sign_q;
    pend_val_d   = pend_val_q;
    pend_valid_d = pend_valid_q;
    disp_d       = disp_q;
    neg_d        = neg_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_i) begin
          mag_d     = ld_mag;
          sign_d    = ld_sign;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // Only the low 16 magnitude bits are shifted in; bit 16 is always 0.
        scratch_d = {adj[BCD_W-2:0], mag_q[DATA_W-1]};
        mag_d     = mag_q << 1;
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = UPDATE;
        end
        if (load_i) begin
          pend_val_d   = value_i;
          pend_valid_d = 1'b1;
        end
      end

      UPDATE: begin
        disp_d = scratch_q;
        neg_d  = sign_q;
        done_d = 1'b1;
        if (load_i || pend_valid_q) begin
          mag_d        = ld_mag;
          sign_d       = ld_sign;
          scratch_d    = '0;
          cnt_d        = '0;
          pend_valid_d = 1'b0;
          state_d      = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any conversion and blanks the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      scratch_q    <= '0;
      mag_q        <= '0;
      sign_q       <= 1'b0;
      pend_val_q   <= '0;
      pend_valid_q <= 1'b0;
      disp_q       <= '0;
      neg_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scratch_q    <= scratch_d;
      mag_q        <= mag_d;
      sign_q       <= sign_d;
      pend_val_q   <= pend_val_d;
      pend_valid_q <= pend_valid_d;
      disp_q       <= disp_d;
      neg_q        <= neg_d;
      done_q       <= done_d;
    end
  end

  assign bcd_digit0 = disp_q[3:0];
  assign bcd_digit1 = disp_q[7:4];
  assign bcd_digit2 = disp_q[11:8];
  assign bcd_digit3 = disp_q[15:12];
  assign bcd_digit4 = disp_q[19:16];
  assign negative   = neg_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;

endmodule

// File: tb/tb_display_bcd_ctrl.sv
// Bench for display_bcd_ctrl: a signed and an unsigned instance share stimulus.
module tb_display_bcd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_i = 1'b0;
  logic [15:0] value_i = '0;

  logic [3:0] sd0, sd1, sd2, sd3, sd4, ud0, ud1, ud2, ud3, ud4;
  logic       sneg, sbusy, sdone, uneg, ubusy, udone;

  display_bcd_ctrl #(.SIGNED_EN(1'b1)) u_dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_i),
    .value_i    (value_i),
    .bcd_digit0 (sd0),
    .bcd_digit1 (sd1),
    .bcd_digit2 (sd2),
    .bcd_digit3 (sd3),
    .bcd_digit4 (sd4),
    .negative   (sneg),
    .busy_o     (sbusy),
    .done_o     (sdone)
  );

  display_bcd_ctrl #(.SIGNED_EN(1'b0)) u_dut_u (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_i),
    .value_i    (value_i),
    .bcd_digit0 (ud0),
    .bcd_digit1 (ud1),
    .bcd_digit2 (ud2),
    .bcd_digit3 (ud3),
    .bcd_digit4 (ud4),
    .negative   (uneg),
    .busy_o     (ubusy),
    .done_o     (udone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic [19:0] exp_s;
    logic        exp_sneg;
    logic [19:0] exp_u;
  } vec_t;

  vec_t vecs[8];

  int checks = 0;
  int errors = 0;

  logic        sched_en[64];
  logic [15:0] sched_val[64];
  logic        busy_h[64], done_h[64], udone_h[64], neg_s[64], neg_u[64];
  logic [19:0] disp_s[64], disp_u[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 64; i++) begin
      sched_en[i]  = 1'b0;
      sched_val[i] = '0;
    end
  endtask

  // Drives load for edge k+j, then samples at the following negedge into slot j.
  task automatic run_sched(input int n);
    for (int j = 0; j < n; j++) begin
      load_i  = sched_en[j];
      value_i = sched_en[j] ? sched_val[j] : 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      busy_h[j]  = sbusy;
      done_h[j]  = sdone;
      udone_h[j] = udone;
      neg_s[j]   = sneg;
      neg_u[j]   = uneg;
      disp_s[j]  = {sd4, sd3, sd2, sd1, sd0};
      disp_u[j]  = {ud4, ud3, ud2, ud1, ud0};
    end
    load_i = 1'b0;
  endtask

  function automatic int count_done(input int n);
    int c = 0;
    for (int j = 0; j < n; j++) if (done_h[j]) c++;
    return c;
  endfunction

  function automatic int count_busy(input int n);
    int c = 0;
    for (int j = 0; j < n; j++) if (busy_h[j]) c++;
    return c;
  endfunction

  function automatic int count_disp(input int n, input logic [19:0] v);
    int c = 0;
    for (int j = 0; j < n; j++) if (disp_s[j] == v) c++;
    return c;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [19:0] prev_s;

    vecs[0] = '{16'h0000, 20'h00000, 1'b0, 20'h00000};
    vecs[1] = '{16'h3039, 20'h12345, 1'b0, 20'h12345};
    vecs[2] = '{16'h8000, 20'h32768, 1'b1, 20'h32768};
    vecs[3] = '{16'hFFFF, 20'h00001, 1'b1, 20'h65535};
    vecs[4] = '{16'hFF85, 20'h00123, 1'b1, 20'h65413};
    vecs[5] = '{16'h7FFF, 20'h32767, 1'b0, 20'h32767};
    vecs[6] = '{16'h03E8, 20'h01000, 1'b0, 20'h01000};
    vecs[7] = '{16'h0063, 20'h00099, 1'b0, 20'h00099};

    repeat (3) @(negedge clk);
    chk("reset_digits", {sd4, sd3, sd2, sd1, sd0}, 20'h0);
    chk("reset_flags", {sneg, sbusy, sdone}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    prev_s = 20'h0;
    for (int v = 0; v < 8; v++) begin
      clear_sched();
      sched_en[0]  = 1'b1;
      sched_val[0] = vecs[v].val;
      run_sched(20);
      chk($sformatf("v%0d_done_at_17", v), done_h[17], 1'b1);
      chk($sformatf("v%0d_done_count", v), count_done(20), 1);
      chk($sformatf("v%0d_busy_cycles", v), count_busy(20), 17);
      chk($sformatf("v%0d_busy_drop", v), {busy_h[16], busy_h[17]}, 2'b10);
      chk($sformatf("v%0d_hold_before_update", v), disp_s[16], prev_s);
      chk($sformatf("v%0d_digits_s", v), disp_s[17], vecs[v].exp_s);
      chk($sformatf("v%0d_neg_s", v), neg_s[17], vecs[v].exp_sneg);
      chk($sformatf("v%0d_digits_u", v), disp_u[17], vecs[v].exp_u);
      chk($sformatf("v%0d_neg_u", v), neg_u[17], 1'b0);
      chk($sformatf("v%0d_done_u", v), udone_h[17], 1'b1);
      prev_s = vecs[v].exp_s;
    end

    // Pending overwrite: 200 is replaced by 300 before it can start.
    clear_sched();
    sched_en[0] = 1'b1; sched_val[0] = 16'd100;
    sched_en[5] = 1'b1; sched_val[5] = 16'd200;
    sched_en[9] = 1'b1; sched_val[9] = 16'd300;
    run_sched(40);
    chk("pend_done_count", count_done(40), 2);
    chk("pend_done_pos", {done_h[17], done_h[34]}, 2'b11);
    chk("pend_first", disp_s[17], 20'h00100);
    chk("pend_second", disp_s[34], 20'h00300);
    chk("pend_never_200", count_disp(40, 20'h00200), 0);
    chk("pend_busy_cycles", count_busy(40), 34);
    chk("pend_busy_end", {busy_h[33], busy_h[34]}, 2'b10);

    // Collision at UPDATE edge: live 42 wins, pending 7 is dropped.
    clear_sched();
    sched_en[0]  = 1'b1; sched_val[0]  = 16'd500;
    sched_en[3]  = 1'b1; sched_val[3]  = 16'd7;
    sched_en[17] = 1'b1; sched_val[17] = 16'd42;
    run_sched(55);
    chk("coll_done_count", count_done(55), 2);
    chk("coll_first", disp_s[17], 20'h00500);
    chk("coll_second", disp_s[34], 20'h00042);
    chk("coll_never_7", count_disp(55, 20'h00007), 0);
    chk("coll_busy_cycles", count_busy(55), 34);

    // Reset at SHIFT cnt=8 abandons the conversion and blanks outputs at once.
    clear_sched();
    sched_en[0] = 1'b1; sched_val[0] = 16'd12345;
    run_sched(9);
    rst_n = 1'b0;
    #1;
    chk("rst_digits_s", {sd4, sd3, sd2, sd1, sd0}, 20'h0);
    chk("rst_digits_u", {ud4, ud3, ud2, ud1, ud0}, 20'h0);
    chk("rst_flags", {sneg, sbusy, sdone, ubusy, udone}, 5'b0);
    repeat (3) @(negedge clk);
    chk("rst_no_done", {sdone, sbusy, sd0}, 6'b0);
    // First load coincides with the first edge after release.
    rst_n = 1'b1;
    clear_sched();
    sched_en[0] = 1'b1; sched_val[0] = 16'd99;
    run_sched(20);
    chk("post_rst_done_count", count_done(20), 1);
    chk("post_rst_done_pos", done_h[17], 1'b1);
    chk("post_rst_hold_zero", disp_s[16], 20'h0);
    chk("post_rst_digits", disp_s[17], 20'h00099);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
